debug_overlay_ctrl: RTL and testbench
=====================================

Name: debug_overlay_ctrl

Overview:
- Sequencing/configuration controller for the fixed-point debug overlay.
- Captures a frame-stable snapshot of the six Q-format vectors (player position, facing, viewplane) at frame start and feeds it to the overlay, so displayed bits never tear mid-frame.
- Debounces a user button that toggles the overlay; supports freeze and single-step of the snapshot.
- Merges overlay pixels over the main renderer's RGB with one registered pipeline stage.

Parameters:
QMN, 24, width of each fixed-point vector (Qm+Qn, Q12.12 default)
DEBOUNCE_BITS, 16, width of debounce counter; a press is stable after 2^DEBOUNCE_BITS-1 consecutive equal samples
ENABLE_AT_RESET, 1, overlay_en value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at the first pixel of each frame (from VGA sync)
debug_btn  in  1  raw asynchronous button, active high
freeze  in  1  level; 1 = hold the current snapshot
step  in  1  one-cycle pulse; while frozen, capture one snapshot at the next frame_start
playerX, playerY, facingX, facingY, vplaneX, vplaneY  in  QMN each  live vectors from game logic
snap_playerX, snap_playerY, snap_facingX, snap_facingY, snap_vplaneX, snap_vplaneY  out  QMN each  frame-stable copies to the overlay
in_debug_overlay  in  1  overlay region flag from the overlay datapath (same cycle as debug_rgb)
debug_rgb  in  6  overlay pixel colour
rgb_in  in  6  main renderer colour, same cycle as debug_rgb
overlay_en  out  1  current overlay enable
rgb_out  out  6  merged colour, registered
btn_event  out  1  one-cycle pulse when a debounced press toggles overlay_en

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - snap_* = 0
  - overlay_en = ENABLE_AT_RESET
  - rgb_out = 0, btn_event = 0
  - debounce FSM = IDLE, counter = 0, synchroniser flops = 0, step_pending = 0
- Button path:
  - debug_btn passes through a 2-flop synchroniser to give btn_s.
  - Debounce FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: btn_s=1 -> PRESS_WAIT, counter cleared.
  - PRESS_WAIT: btn_s=0 -> IDLE. Otherwise the counter increments. When the counter reaches all-ones -> HELD, overlay_en toggles and btn_event=1 for that single cycle.
  - HELD: btn_s=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: btn_s=1 -> HELD. When the counter reaches all-ones -> IDLE.
  - One toggle per press; holding the button never repeats. The counter saturates and never wraps.
- Snapshot capture, evaluated on a frame_start cycle:
  - capture = !freeze || step_pending || step.
  - When capture is true, all six snap_* load the live inputs in that same edge, atomically.
  - step_pending sets on step when freeze=1 and frame_start=0. It clears on the capture edge, and on freeze=0.
  - step while freeze=0 is ignored.
  - step and frame_start in the same cycle while frozen: capture on that edge, step_pending stays 0.
  - Between frame_start pulses snap_* are constant, whatever the live inputs do.
- Merge pipeline, latency 1 cycle:
  - rgb_out <= (overlay_en && in_debug_overlay) ? debug_rgb : rgb_in.
  - overlay_en is taken as its value before any toggle in the same edge.
  - A toggle mid-frame takes effect on the next pixel; no frame alignment.
- Reset mid-press returns the FSM to IDLE. A still-held button must re-debounce and toggles once.
- Reset mid-frame clears the snapshot to 0 until the next frame_start.
- No combinational path from any input to any output.

Test Plan:
- Reset, DEBOUNCE_BITS=4 -> overlay_en=1, snap_*=0, rgb_out=0. Hold debug_btn=1 for 40 cycles -> exactly one btn_event, 17 cycles after btn_s rises; overlay_en=0.
- Glitch: debug_btn high for 10 cycles, low, high again for 10 cycles (DEBOUNCE_BITS=4) -> no btn_event, overlay_en unchanged.
- freeze=0, playerX changes from 0x001800 to 0x002400 mid-frame -> snap_playerX holds 0x001800 until the frame_start edge, then 0x002400. All six snap_* update on the same edge.
- freeze=1, live vectors changing -> snap_* unchanged across 3 frame_starts. Pulse step mid-frame -> exactly one capture at the next frame_start; the following frame_start does not capture. Step coinciding with frame_start -> capture on that edge only.
- overlay_en=1, in_debug_overlay=1, debug_rgb=6'h3F, rgb_in=6'h05 -> rgb_out=6'h3F one cycle later. With in_debug_overlay=0 -> 6'h05. With overlay_en=0 -> 6'h05.
- Assert reset during PRESS_WAIT with the button held -> overlay_en=ENABLE_AT_RESET, no btn_event from the interrupted press, one toggle after a full re-debounce.

Source files
------------

// File: rtl/debug_overlay_ctrl.sv
// debug_overlay_ctrl
//
// Sequencing and configuration controller for the fixed-point debug overlay.
//   - Latches a frame-stable snapshot of six Q-format vectors on frame_start so
//     the overlay never shows bits that change part-way through a frame.
//   - Synchronises and debounces a raw push button; each debounced press toggles
//     overlay_en exactly once and emits a one-cycle btn_event.
//   - freeze holds the snapshot; step requests one capture at the next frame_start.
//   - Merges overlay pixels over the main renderer colour through one register.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   frame_start                 one-cycle pulse at the first pixel of a frame
//   debug_btn                   raw asynchronous button, active high
//   freeze, step                snapshot hold level / single-step pulse
//   playerX .. vplaneY          live vectors (QMN bits each)
//   snap_playerX .. snap_vplaneY  frame-stable copies (registered)
//   in_debug_overlay, debug_rgb overlay region flag and colour
//   rgb_in                      main renderer colour, aligned with debug_rgb
//   overlay_en                  current overlay enable (registered)
//   rgb_out                     merged colour, one cycle after the inputs
//   btn_event                   one-cycle pulse on each debounced toggle
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.

module debug_overlay_ctrl #(
  parameter int unsigned QMN             = 24,
  parameter int unsigned DEBOUNCE_BITS   = 16,
  parameter bit          ENABLE_AT_RESET = 1'b1
) (
  input  logic           clk,
  input  logic           reset,

  input  logic           frame_start,
  input  logic           debug_btn,
  input  logic           freeze,
  input  logic           step,

  input  logic [QMN-1:0] playerX,
  input  logic [QMN-1:0] playerY,
  input  logic [QMN-1:0] facingX,
  input  logic [QMN-1:0] facingY,
  input  logic [QMN-1:0] vplaneX,
  input  logic [QMN-1:0] vplaneY,

  output logic [QMN-1:0] snap_playerX,
  output logic [QMN-1:0] snap_playerY,
  output logic [QMN-1:0] snap_facingX,
  output logic [QMN-1:0] snap_facingY,
  output logic [QMN-1:0] snap_vplaneX,
  output logic [QMN-1:0] snap_vplaneY,

  input  logic           in_debug_overlay,
  input  logic [5:0]     debug_rgb,
  input  logic [5:0]     rgb_in,

  output logic           overlay_en,
  output logic [5:0]     rgb_out,
  output logic           btn_event
);

  localparam logic [DEBOUNCE_BITS-1:0] CntMax = '1;
  localparam logic [DEBOUNCE_BITS-1:0] CntOne = DEBOUNCE_BITS'(1);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StHeld,
    StReleaseWait
  } db_state_e;

  // --------------------------------------------------------------------------
  // Button synchroniser
  // --------------------------------------------------------------------------
  logic btn_meta_q;
  logic btn_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      btn_meta_q <= debug_btn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  db_state_e                db_state_q, db_state_d;
  logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
  logic                     toggle;

  always_ff @(posedge clk) begin
    if (reset) begin
      db_state_q <= StIdle;
      cnt_q      <= '0;
    end else begin
      db_state_q <= db_state_d;
      cnt_q      <= cnt_d;
    end
  end

  // The transition fires on the cycle that observes the counter already at
  // all-ones, so the counter itself never has to wrap or saturate explicitly.
  always_comb begin
    db_state_d = db_state_q;
    cnt_d      = cnt_q;
    toggle     = 1'b0;
    unique case (db_state_q)
      StIdle: begin
        if (btn_s_q) begin
          db_state_d = StPressWait;
          cnt_d      = '0;
        end
      end
      StPressWait: begin
        if (!btn_s_q) begin
          db_state_d = StIdle;
        end else if (cnt_q == CntMax) begin
          db_state_d = StHeld;
          toggle     = 1'b1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (!btn_s_q) begin
          db_state_d = StReleaseWait;
          cnt_d      = '0;
        end
      end
      StReleaseWait: begin
        if (btn_s_q) begin
          db_state_d = StHeld;
        end else if (cnt_q == CntMax) begin
          db_state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        db_state_d = StIdle;
        cnt_d      = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Overlay enable and press event
  // --------------------------------------------------------------------------
  logic overlay_en_q;
  logic btn_event_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overlay_en_q <= ENABLE_AT_RESET;
      btn_event_q  <= 1'b0;
    end else begin
      overlay_en_q <= overlay_en_q ^ toggle;
      btn_event_q  <= toggle;
    end
  end

  // --------------------------------------------------------------------------
  // Snapshot capture
  // --------------------------------------------------------------------------
  logic step_pending_q, step_pending_d;
  logic capture;

  assign capture = frame_start && (!freeze || step_pending_q || step);

  // A pending step only survives while frozen and between frame starts; any
  // frame_start while frozen either consumes it or finds none to consume.
  assign step_pending_d = freeze && !frame_start && (step_pending_q || step);

  logic [QMN-1:0] snap_player_x_q, snap_player_y_q;
  logic [QMN-1:0] snap_facing_x_q, snap_facing_y_q;
  logic [QMN-1:0] snap_vplane_x_q, snap_vplane_y_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_pending_q  <= 1'b0;
      snap_player_x_q <= '0;
      snap_player_y_q <= '0;
      snap_facing_x_q <= '0;
      snap_facing_y_q <= '0;
      snap_vplane_x_q <= '0;
      snap_vplane_y_q <= '0;
    end else begin
      step_pending_q <= step_pending_d;
      if (capture) begin
        snap_player_x_q <= playerX;
        snap_player_y_q <= playerY;
        snap_facing_x_q <= facingX;
        snap_facing_y_q <= facingY;
        snap_vplane_x_q <= vplaneX;
        snap_vplane_y_q <= vplaneY;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Colour merge
  // --------------------------------------------------------------------------
  logic [5:0] rgb_q, rgb_d;

  // Uses the pre-toggle enable, so a press takes effect on the following pixel.
  always_comb begin
    rgb_d = rgb_in;
    if (overlay_en_q && in_debug_overlay) begin
      rgb_d = debug_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign snap_playerX = snap_player_x_q;
  assign snap_playerY = snap_player_y_q;
  assign snap_facingX = snap_facing_x_q;
  assign snap_facingY = snap_facing_y_q;
  assign snap_vplaneX = snap_vplane_x_q;
  assign snap_vplaneY = snap_vplane_y_q;
  assign overlay_en   = overlay_en_q;
  assign rgb_out      = rgb_q;
  assign btn_event    = btn_event_q;

endmodule

// File: tb/tb_debug_overlay_ctrl.sv
// Directed bench for debug_overlay_ctrl with a short debounce counter.
module tb_debug_overlay_ctrl;

  localparam int unsigned QMN = 24;
  localparam int unsigned DB  = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_start;
  logic           debug_btn;
  logic           freeze;
  logic           step;
  logic [QMN-1:0] playerX, playerY, facingX, facingY, vplaneX, vplaneY;
  logic [QMN-1:0] snap_playerX, snap_playerY, snap_facingX, snap_facingY;
  logic [QMN-1:0] snap_vplaneX, snap_vplaneY;
  logic           in_debug_overlay;
  logic [5:0]     debug_rgb;
  logic [5:0]     rgb_in;
  logic           overlay_en;
  logic [5:0]     rgb_out;
  logic           btn_event;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  debug_overlay_ctrl #(
    .QMN             (QMN),
    .DEBOUNCE_BITS   (DB),
    .ENABLE_AT_RESET (1'b1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .debug_btn        (debug_btn),
    .freeze           (freeze),
    .step             (step),
    .playerX          (playerX),
    .playerY          (playerY),
    .facingX          (facingX),
    .facingY          (facingY),
    .vplaneX          (vplaneX),
    .vplaneY          (vplaneY),
    .snap_playerX     (snap_playerX),
    .snap_playerY     (snap_playerY),
    .snap_facingX     (snap_facingX),
    .snap_facingY     (snap_facingY),
    .snap_vplaneX     (snap_vplaneX),
    .snap_vplaneY     (snap_vplaneY),
    .in_debug_overlay (in_debug_overlay),
    .debug_rgb        (debug_rgb),
    .rgb_in           (rgb_in),
    .overlay_en       (overlay_en),
    .rgb_out          (rgb_out),
    .btn_event        (btn_event)
  );

  wire [6*QMN-1:0] snap_all = {snap_playerX, snap_playerY, snap_facingX,
                               snap_facingY, snap_vplaneX, snap_vplaneY};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6*QMN-1:0] vec_of(input logic [QMN-1:0] b);
    return {b, b + 24'h000011, b + 24'h000022, b + 24'h000033, b + 24'h000044,
            b + 24'h000055};
  endfunction

  task automatic set_live(input logic [QMN-1:0] b);
    playerX = b;
    playerY = b + 24'h000011;
    facingX = b + 24'h000022;
    facingY = b + 24'h000033;
    vplaneX = b + 24'h000044;
    vplaneY = b + 24'h000055;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rgb_in = 6'h05;
    tick();
    tick();
    n_vec++;
    if (overlay_en !== 1'b1) begin
      n_err++;
      $display("FAIL reset_overlay_en: got %b want 1", overlay_en);
    end
    n_vec++;
    if (snap_all !== '0) begin
      n_err++;
      $display("FAIL reset_snap: got %h want 0", snap_all);
    end
    n_vec++;
    if (rgb_out !== 6'h00) begin
      n_err++;
      $display("FAIL reset_rgb_out: got %h want 00", rgb_out);
    end
    n_vec++;
    if (btn_event !== 1'b0) begin
      n_err++;
      $display("FAIL reset_btn_event: got %b want 0", btn_event);
    end
    reset = 1'b0;
  endtask

  task automatic test_merge_enabled();
    in_debug_overlay = 1'b1;
    debug_rgb = 6'h3F;
    rgb_in = 6'h05;
    n_vec++;
    if (rgb_out !== 6'h00) begin
      n_err++;
      $display("FAIL merge_latency: got %h want 00", rgb_out);
    end
    tick();
    n_vec++;
    if (rgb_out !== 6'h3F) begin
      n_err++;
      $display("FAIL merge_overlay: got %h want 3f", rgb_out);
    end
    in_debug_overlay = 1'b0;
    tick();
    n_vec++;
    if (rgb_out !== 6'h05) begin
      n_err++;
      $display("FAIL merge_outside: got %h want 05", rgb_out);
    end
  endtask

  task automatic test_debounce_hold();
    int events = 0;
    int first = 0;
    debug_btn = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (btn_event) begin
        events++;
        if (first == 0) first = i;
      end
      if (i == 18) begin
        n_vec++;
        if (overlay_en !== 1'b1) begin
          n_err++;
          $display("FAIL hold_pre_toggle: got %b want 1", overlay_en);
        end
      end
    end
    n_vec++;
    if (events != 1) begin
      n_err++;
      $display("FAIL hold_event_count: got %0d want 1", events);
    end
    n_vec++;
    if (first != 19) begin
      n_err++;
      $display("FAIL hold_event_time: got tick %0d want 19", first);
    end
    n_vec++;
    if (overlay_en !== 1'b0) begin
      n_err++;
      $display("FAIL hold_overlay_en: got %b want 0", overlay_en);
    end
    debug_btn = 1'b0;
    events = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (btn_event) events++;
    end
    n_vec++;
    if (events != 0) begin
      n_err++;
      $display("FAIL release_events: got %0d want 0", events);
    end
  endtask

  task automatic test_glitch();
    int events = 0;
    debug_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (btn_event) events++; end
    debug_btn = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (btn_event) events++; end
    debug_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (btn_event) events++; end
    debug_btn = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (btn_event) events++; end
    n_vec++;
    if (events != 0) begin
      n_err++;
      $display("FAIL glitch_events: got %0d want 0", events);
    end
    n_vec++;
    if (overlay_en !== 1'b0) begin
      n_err++;
      $display("FAIL glitch_overlay_en: got %b want 0", overlay_en);
    end
  endtask

  task automatic test_merge_disabled();
    in_debug_overlay = 1'b1;
    debug_rgb = 6'h3F;
    rgb_in = 6'h05;
    tick();
    n_vec++;
    if (rgb_out !== 6'h05) begin
      n_err++;
      $display("FAIL merge_disabled: got %h want 05", rgb_out);
    end
    debug_rgb = 6'h2A;
    rgb_in = 6'h11;
    tick();
    n_vec++;
    if (rgb_out !== 6'h11) begin
      n_err++;
      $display("FAIL merge_disabled2: got %h want 11", rgb_out);
    end
    in_debug_overlay = 1'b0;
  endtask

  task automatic test_snapshot_live();
    freeze = 1'b0;
    set_live(24'h001800);
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h001800)) begin
      n_err++;
      $display("FAIL live_first: got %h want %h", snap_all, vec_of(24'h001800));
    end
    set_live(24'h002400);
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (snap_playerX !== 24'h001800) begin
      n_err++;
      $display("FAIL live_midframe_px: got %h want 001800", snap_playerX);
    end
    n_vec++;
    if (snap_all !== vec_of(24'h001800)) begin
      n_err++;
      $display("FAIL live_midframe: got %h want %h", snap_all, vec_of(24'h001800));
    end
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h002400)) begin
      n_err++;
      $display("FAIL live_update: got %h want %h", snap_all, vec_of(24'h002400));
    end
  endtask

  task automatic test_freeze_step();
    freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      set_live(24'h100000 + 24'(f * 24'h010000));
      for (int i = 0; i < 3; i++) tick();
      pulse_frame();
      n_vec++;
      if (snap_all !== vec_of(24'h002400)) begin
        n_err++;
        $display("FAIL frozen_%0d: got %h want %h", f, snap_all, vec_of(24'h002400));
      end
    end
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    set_live(24'h0A0000);
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (snap_all !== vec_of(24'h002400)) begin
      n_err++;
      $display("FAIL step_early: got %h want %h", snap_all, vec_of(24'h002400));
    end
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h0A0000)) begin
      n_err++;
      $display("FAIL step_capture: got %h want %h", snap_all, vec_of(24'h0A0000));
    end
    set_live(24'h0B0000);
    for (int i = 0; i < 3; i++) tick();
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h0A0000)) begin
      n_err++;
      $display("FAIL step_once: got %h want %h", snap_all, vec_of(24'h0A0000));
    end
    set_live(24'h0C0000);
    step = 1'b1;
    frame_start = 1'b1;
    tick();
    step = 1'b0;
    frame_start = 1'b0;
    n_vec++;
    if (snap_all !== vec_of(24'h0C0000)) begin
      n_err++;
      $display("FAIL step_coincide: got %h want %h", snap_all, vec_of(24'h0C0000));
    end
    set_live(24'h0D0000);
    tick();
    tick();
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h0C0000)) begin
      n_err++;
      $display("FAIL coincide_no_pending: got %h want %h", snap_all, vec_of(24'h0C0000));
    end
    // step while unfrozen must not leave a pending capture behind
    freeze = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    set_live(24'h0E0000);
    freeze = 1'b1;
    tick();
    pulse_frame();
    n_vec++;
    if (snap_all !== vec_of(24'h0C0000)) begin
      n_err++;
      $display("FAIL unfrozen_step: got %h want %h", snap_all, vec_of(24'h0C0000));
    end
    freeze = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    int events = 0;
    int first = 0;
    debug_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (btn_event) events++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (overlay_en !== 1'b1) begin
      n_err++;
      $display("FAIL midpress_overlay_en: got %b want 1", overlay_en);
    end
    n_vec++;
    if (snap_all !== '0) begin
      n_err++;
      $display("FAIL midpress_snap: got %h want 0", snap_all);
    end
    n_vec++;
    if (rgb_out !== 6'h00) begin
      n_err++;
      $display("FAIL midpress_rgb: got %h want 00", rgb_out);
    end
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (btn_event) begin
        events++;
        if (first == 0) first = i;
      end
    end
    n_vec++;
    if (events != 1) begin
      n_err++;
      $display("FAIL midpress_events: got %0d want 1", events);
    end
    n_vec++;
    if (first != 19) begin
      n_err++;
      $display("FAIL midpress_time: got tick %0d want 19", first);
    end
    n_vec++;
    if (overlay_en !== 1'b0) begin
      n_err++;
      $display("FAIL midpress_toggle: got %b want 0", overlay_en);
    end
    n_vec++;
    if (snap_all !== '0) begin
      n_err++;
      $display("FAIL midpress_snap_hold: got %h want 0", snap_all);
    end
    debug_btn = 1'b0;
    for (int i = 0; i < 40; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    debug_btn = 1'b0;
    freeze = 1'b0;
    step = 1'b0;
    set_live(24'h000000);
    in_debug_overlay = 1'b0;
    debug_rgb = 6'h00;
    rgb_in = 6'h00;

    test_reset();
    test_merge_enabled();
    test_debounce_hold();
    test_glitch();
    test_merge_disabled();
    test_snapshot_live();
    test_freeze_step();
    test_reset_mid_press();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
